// File: rtl/ir_pkg.sv
// ir_pkg: shared state type, timing helpers and pattern ROM
// contents for the IR burst generator.
package ir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_GAP,
    S_DONE
  } ir_state_e;

  localparam int PAT_N = 8;
  typedef logic [15:0] pat_t [PAT_N];

  localparam pat_t PAT0 = '{
    16'd2000, 16'd28000, 16'd400, 16'd1580,
    16'd400, 16'd3580, 16'd400, 16'd0
  };
  localparam pat_t PAT1 = '{
    16'd500, 16'd0, 16'd0, 16'd0,
    16'd0, 16'd0, 16'd0, 16'd0
  };

  function automatic int us_div(input int clk_hz);
    return clk_hz / 1000000;
  endfunction

  function automatic int half_clks(input int clk_hz,
                                   input int car_hz);
    return (clk_hz + car_hz) / (2 * car_hz);
  endfunction

  // Patterns 2 and 3 are reserved and read as all-zero.
  function automatic logic [15:0] pat_len(
    input logic [1:0]  cmd,
    input int unsigned idx
  );
    logic [15:0] len;
    len = '0;
    if (idx < PAT_N) begin
      case (cmd)
        2'd0:    len = PAT0[idx[2:0]];
        2'd1:    len = PAT1[idx[2:0]];
        default: len = '0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/ir_pattern_rom.sv
// ir_pattern_rom: combinational segment-length lookup
// (pattern, segment index) -> length in microseconds.
module ir_pattern_rom
  import ir_pkg::*;
#(
  parameter int NUM_SEG = 8,
  parameter int LEN_W   = 16,
  parameter int IDX_W   = 3
) (
  input  logic [1:0]       cmd_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [LEN_W-1:0] len_o
);

  always_comb begin
    len_o = '0;
    if (int'(idx_i) < NUM_SEG)
      len_o = LEN_W'(pat_len(cmd_i, 32'(idx_i)));
  end

endmodule

// File: rtl/ir_burst_gen.sv
// ir_burst_gen: plays a mark/space pattern with carrier
// modulation, optional repeats and inter-frame gap.
module ir_burst_gen
  import ir_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int CARRIER_HZ = 38000,
  parameter int NUM_SEG    = 8,
  parameter int LEN_W      = 16,
  parameter int GAP_US     = 63000,
  parameter int OUT_INV    = 0
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] cmd_sel,
  input  logic [3:0] rep_cnt,
  output logic       busy,
  output logic       done,
  output logic       env,
  output logic       ir_out
);

  localparam int US_DIV = us_div(CLK_HZ);
  localparam int HALF   = half_clks(CLK_HZ, CARRIER_HZ);
  localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GW = $clog2(GAP_US + 1);
  localparam int SW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic INV = (OUT_INV != 0);

  ir_state_e        state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [3:0]       rep_q, rep_d;
  logic [SW-1:0]    seg_q, seg_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [LEN_W-1:0] us_q, us_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CW-1:0]    ccnt_q, ccnt_d;
  logic             car_q, car_d;

  logic             idle, tick_us, last_seg;
  logic             seg_end, gap_end;
  logic [1:0]       rom_cmd;
  logic [SW-1:0]    rom_idx, nxt_idx;
  logic [LEN_W-1:0] cur_len, nxt_len;

  assign idle     = (state_q == S_IDLE);
  assign rom_cmd  = idle ? cmd_sel : cmd_q;
  assign rom_idx  = idle ? '0 : seg_q;
  assign nxt_idx  = seg_q + SW'(1);
  assign last_seg = (seg_q == SW'(NUM_SEG - 1));
  assign tick_us  = (pre_q == PW'(US_DIV - 1));
  assign seg_end  = tick_us && (us_q == cur_len - LEN_W'(1));
  assign gap_end  = tick_us && (gap_q == GW'(GAP_US - 1));

  // In IDLE the current-length port looks at seg0 of the request.
  ir_pattern_rom #(
    .NUM_SEG(NUM_SEG), .LEN_W(LEN_W), .IDX_W(SW)
  ) u_rom_cur (
    .cmd_i(rom_cmd), .idx_i(rom_idx), .len_o(cur_len)
  );

  ir_pattern_rom #(
    .NUM_SEG(NUM_SEG), .LEN_W(LEN_W), .IDX_W(SW)
  ) u_rom_nxt (
    .cmd_i(cmd_q), .idx_i(nxt_idx), .len_o(nxt_len)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rep_d   = rep_q;
    seg_d   = seg_q;
    us_d    = us_q;
    gap_d   = gap_q;
    pre_d   = tick_us ? '0 : pre_q + PW'(1);
    unique case (state_q)
      S_IDLE: begin
        pre_d = '0;
        us_d  = '0;
        gap_d = '0;
        if (start && !abort) begin
          cmd_d   = cmd_sel;
          rep_d   = rep_cnt;
          seg_d   = '0;
          state_d = (cur_len == '0) ? S_DONE : S_MARK;
        end
      end
      S_MARK, S_SPACE: begin
        if (tick_us) us_d = us_q + LEN_W'(1);
        if (seg_end) begin
          us_d = '0;
          if (!last_seg && nxt_len != '0) begin
            seg_d   = nxt_idx;
            state_d = nxt_idx[0] ? S_SPACE : S_MARK;
          end else if (rep_q != '0) begin
            rep_d   = rep_q - 4'd1;
            state_d = S_GAP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (tick_us) gap_d = gap_q + GW'(1);
        if (gap_end) begin
          gap_d   = '0;
          seg_d   = '0;
          state_d = S_MARK;
        end
      end
      S_DONE: begin
        pre_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && !idle) begin
      state_d = S_IDLE;
      pre_d   = '0;
      us_d    = '0;
      gap_d   = '0;
    end
  end

  // Carrier parks high outside MARK so each mark opens high.
  always_comb begin
    ccnt_d = '0;
    car_d  = 1'b1;
    if (state_q == S_MARK) begin
      if (ccnt_q == CW'(HALF - 1)) begin
        car_d = ~car_q;
      end else begin
        ccnt_d = ccnt_q + CW'(1);
        car_d  = car_q;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      rep_q   <= '0;
      seg_q   <= '0;
      pre_q   <= '0;
      us_q    <= '0;
      gap_q   <= '0;
      ccnt_q  <= '0;
      car_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rep_q   <= rep_d;
      seg_q   <= seg_d;
      pre_q   <= pre_d;
      us_q    <= us_d;
      gap_q   <= gap_d;
      ccnt_q  <= ccnt_d;
      car_q   <= car_d;
    end
  end

  assign busy   = !idle;
  assign done   = (state_q == S_DONE);
  assign env    = (state_q == S_MARK);
  assign ir_out = (env & car_q) ^ INV;

endmodule

// File: tb/tb_ir_burst_gen.sv
// tb_ir_burst_gen: directed stimulus with a segment-queue
// reference model and per-cycle output comparison.
module tb_ir_burst_gen;

  localparam int CLK_A  = 1000000;
  localparam int CAR_A  = 100000;
  localparam int GAP_A  = 300;
  localparam int UD_A   = 1;
  localparam int HALF_A = 5;
  localparam int CLK_B  = 2000000;
  localparam int CAR_B  = 200000;
  localparam int BUDGET = 40000;

  logic clk = 1'b0;
  logic rst_n, start, abort, start_b, abort_b;
  logic [1:0] cmd_sel, cmd_b;
  logic [3:0] rep_cnt, rep_b;
  logic busy, done, env, ir_out;
  logic busy_b, done_b, env_b, ir_b;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ir_burst_gen #(
    .CLK_HZ(CLK_A), .CARRIER_HZ(CAR_A), .NUM_SEG(8),
    .LEN_W(16), .GAP_US(GAP_A), .OUT_INV(0)
  ) dut (
    .clk_50M(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .cmd_sel(cmd_sel), .rep_cnt(rep_cnt),
    .busy(busy), .done(done), .env(env), .ir_out(ir_out)
  );

  ir_burst_gen #(
    .CLK_HZ(CLK_B), .CARRIER_HZ(CAR_B), .NUM_SEG(8),
    .LEN_W(16), .GAP_US(GAP_A), .OUT_INV(1)
  ) dut_b (
    .clk_50M(clk), .rst_n(rst_n), .start(start_b),
    .abort(abort_b), .cmd_sel(cmd_b), .rep_cnt(rep_b),
    .busy(busy_b), .done(done_b), .env(env_b), .ir_out(ir_b)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      if (nerr <= 20)
        $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: the frame as a queue of timed segments.
  typedef struct {
    int kind;
    int len;
    int el;
  } seg_t;

  seg_t mq[$];
  int pat [4][8] = '{
    '{2000, 28000, 400, 1580, 400, 3580, 400, 0},
    '{500, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0}
  };

  function automatic void build(input int c, input int r);
    seg_t s;
    if (pat[c][0] != 0) begin
      for (int f = 0; f <= r; f++) begin
        if (f > 0) begin
          s = '{0, GAP_A * UD_A, 0};
          mq.push_back(s);
        end
        for (int i = 0; i < 8 && pat[c][i] != 0; i++) begin
          s = '{(i % 2 == 0) ? 1 : 0, pat[c][i] * UD_A, 0};
          mq.push_back(s);
        end
      end
    end
    s = '{2, 1, 0};
    mq.push_back(s);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) mq.delete();
    else if (mq.size() != 0 && abort) mq.delete();
    else if (mq.size() == 0) begin
      if (start && !abort) build(int'(cmd_sel), int'(rep_cnt));
    end else begin
      mq[0].el++;
      if (mq[0].el == mq[0].len) void'(mq.pop_front());
    end
  end

  always @(posedge clk) begin
    int eb, ed, ee, ei;
    #1;
    if (chk_en) begin
      eb = 0; ed = 0; ee = 0; ei = 0;
      if (mq.size() != 0) begin
        eb = 1;
        ed = (mq[0].kind == 2) ? 1 : 0;
        ee = (mq[0].kind == 1) ? 1 : 0;
        ei = (ee == 1 && (mq[0].el / HALF_A) % 2 == 0) ? 1 : 0;
      end
      chk("m_busy", busy, eb);
      chk("m_done", done, ed);
      chk("m_env", env, ee);
      chk("m_ir", ir_out, ei);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run(input int c, input int r,
                     output int nb, output int ne,
                     output int nd, output int ir1,
                     output int ir6);
    cmd_sel = 2'(c); rep_cnt = 4'(r); start = 1'b1;
    tick();
    start = 1'b0; cmd_sel = 2'd3; rep_cnt = 4'd15;
    nb = 0; ne = 0; nd = 0; ir1 = -1; ir6 = -1;
    while (busy && nb < BUDGET) begin
      nb++;
      ne += int'(env);
      nd += int'(done);
      if (nb == 1) ir1 = int'(ir_out);
      if (nb == 6) ir6 = int'(ir_out);
      start = (nb == 100);
      tick();
    end
    start = 1'b0;
    if (nb >= BUDGET) chk("run_timeout", nb, -1);
  endtask

  initial begin
    int nb, ne, nd, ir1, ir6;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cmd_sel = '0; rep_cnt = '0;
    start_b = 1'b0; abort_b = 1'b0;
    cmd_b = 2'd1; rep_b = '0;
    tick();
    chk_en = 1'b1;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_env", env, 0);
    chk("idle_ir", ir_out, 0);
    chk("idleB_ir", ir_b, 1);

    run(0, 0, nb, ne, nd, ir1, ir6);
    chk("p0_busy_cycles", nb, 36361);
    chk("p0_env_cycles", ne, 3200);
    chk("p0_done_count", nd, 1);
    chk("p0_ir_first", ir1, 1);
    chk("p0_ir_half", ir6, 0);
    tick();

    run(1, 2, nb, ne, nd, ir1, ir6);
    chk("p1r2_busy_cycles", nb, 2101);
    chk("p1r2_env_cycles", ne, 1500);
    chk("p1r2_done_count", nd, 1);
    tick();

    run(2, 3, nb, ne, nd, ir1, ir6);
    chk("p2_busy_cycles", nb, 1);
    chk("p2_env_cycles", ne, 0);
    chk("p2_done_count", nd, 1);
    tick();

    cmd_sel = 2'd0; rep_cnt = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (999) tick();
    chk("ab_env_before", env, 1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_env", env, 0);
    nd = 0; nb = 0;
    repeat (20) begin
      nd += int'(done);
      nb += int'(busy);
      tick();
    end
    chk("ab_no_done", nd, 0);
    chk("ab_stays_idle", nb, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("ab_start_busy", busy, 0);
    chk("ab_start_env", env, 0);

    cmd_sel = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_env", env, 0);
    chk("rst_done", done, 0);
    chk("rst_ir", ir_out, 0);
    tick();

    chk("b_idle_ir", ir_b, 1);
    cmd_b = 2'd1; rep_b = 4'd0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    nb = 0; ne = 0; nd = 0; ir1 = -1; ir6 = -1;
    while (busy_b && nb < BUDGET) begin
      nb++;
      ne += int'(env_b);
      nd += int'(done_b);
      if (nb == 1) ir1 = int'(ir_b);
      if (nb == 6) ir6 = int'(ir_b);
      tick();
    end
    chk("b_busy_cycles", nb, 1001);
    chk("b_env_cycles", ne, 1000);
    chk("b_done_count", nd, 1);
    chk("b_ir_first", ir1, 0);
    chk("b_ir_half", ir6, 1);
    chk("b_ir_after", ir_b, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
